writeback_pipe: RTL and testbench
=================================

# writeback_pipe

Registered, handshaked write-back stage for the pipelined core. It sits between the memory stage and the register file and fetch redirect. It accepts one instruction per cycle, waits a variable number of cycles for load data, and aligns and extends sub-word loads. It commits exactly one register-file write and one next-PC decision per instruction, and counts retired instructions.

## Interface
Parameters:
- DWIDTH, DATA_WIDTH: datapath width; legal values 32 or 64.
- AWIDTH, ADDR_WIDTH: PC/address width.
- RWIDTH, 5: register index width.
- CWIDTH, 32: retire counter width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  memory stage presents an instruction.
- in_ready_o  out  1  stage can accept this cycle.
- pc_i  in  AWIDTH  instruction PC.
- alu_res_i  in  DWIDTH  ALU result, load address or branch/jump target.
- rd_i  in  RWIDTH  destination register.
- rdwe_i  in  1  instruction writes rd.
- wbsel_i  in  2  00 ALU, 01 MEM, 10 PC+4, 11 ALU.
- is_load_i  in  1  instruction waits for mem_rvalid_i.
- ld_funct3_i  in  3  load size/sign selector.
- pcsel_i  in  1  unconditional jump.
- brtaken_i  in  1  branch taken.
- flush_i  in  1  kill incoming and pending-load instruction.
- mem_rvalid_i  in  1  load data valid, single-cycle pulse.
- mem_rdata_i  in  DWIDTH  raw aligned-word read data.
- rf_we_o  out  1  register-file write strobe.
- rf_waddr_o  out  RWIDTH  write index.
- rf_wdata_o  out  DWIDTH  write data.
- redirect_o  out  1  next_pc_o is a taken target.
- commit_o  out  1  instruction retired this cycle.
- next_pc_o  out  AWIDTH  PC following the committed instruction.
- retired_o  out  CWIDTH  retired-instruction count.

## Operation
- The FSM has four states: IDLE, WAIT, COMMIT and DRAIN.
- An instruction is accepted when `in_valid_i && in_ready_o && !flush_i`. On acceptance, all inputs are captured into a holding register.
- in_ready_o is 1 in IDLE and COMMIT, and 0 in WAIT and DRAIN.
- IDLE and COMMIT transitions:
  - accept with is_load_i → WAIT.
  - accept without a load → COMMIT.
  - no accept → IDLE.
- WAIT transitions:
  - mem_rvalid_i → COMMIT. The aligned load result is captured and flush_i is ignored in that cycle.
  - flush_i without mem_rvalid_i → DRAIN.
- DRAIN: wait for mem_rvalid_i, discard the data, then go to IDLE. Nothing commits.
- COMMIT: the outputs below are valid for exactly that cycle. flush_i never cancels an instruction already in COMMIT.
  - commit_o = 1.
  - rf_we_o = rdwe && (rd != 0).
  - redirect_o = pcsel || brtaken.
  - next_pc_o = redirect ? {alu_res[AWIDTH-1:1], 1'b0} : pc + WORD_STRIDE.
- Outside COMMIT, commit_o, rf_we_o and redirect_o are 0. Data outputs hold their last value.
- Write-data mux:
  - ALU → alu_res.
  - MEM → aligned load.
  - PC+4 → pc + WORD_STRIDE, zero-extended to DWIDTH.
- Load alignment:
  - The byte offset is alu_res[log2(DWIDTH/8)-1:0].
  - The lane is selected at offset×8 for bytes and offset[..:1]×16 for halves.
  - Selector codes: 000 LB sign-extend, 001 LH sign-extend, 010 LW (sign-extend when DWIDTH = 64), 011 LD (full word, DWIDTH = 64 only), 100 LBU, 101 LHU, 110 LWU.
  - Any other selector code returns the raw mem_rdata_i.
  - Misaligned halves and words use the truncated offset. No trap is raised.
- retired_o increments by 1 on every COMMIT cycle, including writes to x0, and wraps modulo 2^CWIDTH.
- mem_rvalid_i in IDLE or COMMIT is ignored.

## Timing
- Reset values while rst_n = 0:
  - The state is IDLE, so in_ready_o = 1.
  - rf_we_o, rf_waddr_o, rf_wdata_o, redirect_o, commit_o and retired_o are 0.
  - next_pc_o is 0.
- Non-load latency: accepted at edge N, commit outputs valid in the cycle after N. Back-to-back throughput is 1 per cycle.
- Load latency: commit is in the cycle after the edge that samples mem_rvalid_i. There is no throughput while in WAIT.
- All outputs are registered, except in_ready_o, which is decoded from state.
- Deasserting rst_n mid-load discards the pending instruction. Any later mem_rvalid_i is ignored, because the FSM is in IDLE.
- Asserting flush_i in the same cycle as in_valid_i blocks acceptance.

## Structure
- Add to constants_pkg:
  - `wbsel_e` (WB_ALU, WB_MEM, WB_PC4).
  - `ld_funct3_e`.
  - `wb_state_e` (IDLE, WAIT, COMMIT, DRAIN).
- WORD_STRIDE is reused from constants_pkg.
- Sub-module `load_align`: a combinational DWIDTH-parametrised lane select and extension, taking (rdata, offset, funct3) and producing the aligned data. It is instantiated once and unit-testable on its own.

## Test plan
- ALU op: pc=0x100, alu=0x1234, rd=5, wbsel=00 → next cycle rf_we=1, waddr=5, wdata=0x1234, next_pc=0x104, retired=1.
- Load: LB at alu=0x2003, rdata=0x80AABBCC, rvalid pulsed 3 cycles after accept → in_ready=0 for those 3 cycles, then wdata=0xFFFFFF80. The same case with LBU gives 0x00000080.
- JALR: pc=0x40, alu=0x2001, pcsel=1, wbsel=10, rd=1 → redirect=1, next_pc=0x2000, wdata=0x44.
- Write to x0: rd=0, rdwe=1 → rf_we=0, commit=1, retired increments.
- Flush during WAIT, then rvalid 2 cycles later → no commit, in_ready=0 until the cycle after rvalid, retired unchanged.
- rst_n asserted during WAIT, then rvalid after release → all outputs 0 and the rvalid is ignored. A following ALU op commits normally with retired=1.

Source files
------------

// File: rtl/constants_pkg.sv
// Shared core constants and enumerations used by the write-back stage.
package constants_pkg;

    localparam int unsigned WORD_STRIDE = 4;

    typedef enum logic [1:0] {
        WB_ALU     = 2'b00,
        WB_MEM     = 2'b01,
        WB_PC4     = 2'b10,
        WB_ALU_ALT = 2'b11
    } wbsel_e;

    typedef enum logic [2:0] {
        LD_LB   = 3'b000,
        LD_LH   = 3'b001,
        LD_LW   = 3'b010,
        LD_LD   = 3'b011,
        LD_LBU  = 3'b100,
        LD_LHU  = 3'b101,
        LD_LWU  = 3'b110,
        LD_RSVD = 3'b111
    } ld_funct3_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        COMMIT = 2'b10,
        DRAIN  = 2'b11
    } wb_state_e;

endpackage

// File: rtl/writeback_pipe_load_align.sv
// Combinational lane select and sign/zero extension of raw load data.
module load_align
    import constants_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0]              rdata_i,
    input  logic [$clog2(DWIDTH/8)-1:0]    offset_i,
    input  logic [2:0]                     funct3_i,
    output logic [DWIDTH-1:0]              data_o
);

    localparam int OW = $clog2(DWIDTH/8);

    logic [OW+2:0] byte_sh;
    logic [OW+2:0] half_sh;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   word_v;

    // Misaligned halves/words simply drop the low offset bits.
    assign byte_sh = {offset_i, 3'b000};
    assign half_sh = {offset_i[OW-1:1], 4'b0000};
    assign byte_v  = 8'(rdata_i >> byte_sh);
    assign half_v  = 16'(rdata_i >> half_sh);

    generate
        if (DWIDTH == 64) begin : g_word64
            assign word_v = 32'(rdata_i >> {offset_i[OW-1], 5'b00000});
        end else begin : g_word32
            assign word_v = 32'(rdata_i);
        end
    endgenerate

    always_comb begin
        data_o = rdata_i;
        case (ld_funct3_e'(funct3_i))
            LD_LB:   data_o = DWIDTH'($signed(byte_v));
            LD_LH:   data_o = DWIDTH'($signed(half_v));
            LD_LW:   data_o = DWIDTH'($signed(word_v));
            LD_LBU:  data_o = DWIDTH'(byte_v);
            LD_LHU:  data_o = DWIDTH'(half_v);
            LD_LWU:  data_o = DWIDTH'(word_v);
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/writeback_pipe.sv
// Handshaked write-back stage: waits for load data, aligns it, and commits
// one register write plus one next-PC decision per accepted instruction.
module writeback_pipe
    import constants_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int RWIDTH = 5,
    parameter int CWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] alu_res_i,
    input  logic [RWIDTH-1:0] rd_i,
    input  logic              rdwe_i,
    input  logic [1:0]        wbsel_i,
    input  logic              is_load_i,
    input  logic [2:0]        ld_funct3_i,
    input  logic              pcsel_i,
    input  logic              brtaken_i,
    input  logic              flush_i,
    input  logic              mem_rvalid_i,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic              rf_we_o,
    output logic [RWIDTH-1:0] rf_waddr_o,
    output logic [DWIDTH-1:0] rf_wdata_o,
    output logic              redirect_o,
    output logic              commit_o,
    output logic [AWIDTH-1:0] next_pc_o,
    output logic [CWIDTH-1:0] retired_o
);

    localparam int OW = $clog2(DWIDTH/8);

    wb_state_e         state_q;
    wb_state_e         state_d;
    logic              accept;
    logic              do_commit;

    logic [AWIDTH-1:0] pc_p0;
    logic [DWIDTH-1:0] alu_p0;
    logic [RWIDTH-1:0] rd_p0;
    logic              rdwe_p0;
    logic [1:0]        wbsel_p0;
    logic [2:0]        funct3_p0;
    logic              pcsel_p0;
    logic              brtaken_p0;

    logic              use_hold;
    logic [AWIDTH-1:0] src_pc;
    logic [DWIDTH-1:0] src_alu;
    logic [RWIDTH-1:0] src_rd;
    logic              src_rdwe;
    logic [1:0]        src_wbsel;
    logic [2:0]        src_funct3;
    logic              src_pcsel;
    logic              src_brtaken;

    logic [DWIDTH-1:0] ld_data;
    logic [AWIDTH-1:0] pc4;
    logic              redirect_d;
    logic              rf_we_d;
    logic [DWIDTH-1:0] wdata_d;
    logic [AWIDTH-1:0] next_pc_d;

    assign in_ready_o = (state_q == IDLE) || (state_q == COMMIT);
    assign accept     = in_valid_i && in_ready_o && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A load that returns in WAIT commits even if flush_i is raised that cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, COMMIT: begin
                if (accept) begin
                    state_d = is_load_i ? WAIT : COMMIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = COMMIT;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign do_commit = (state_d == COMMIT);

    // ---- stage p0: holding register for the accepted instruction ----
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_p0      <= pc_i;
            alu_p0     <= alu_res_i;
            rd_p0      <= rd_i;
            rdwe_p0    <= rdwe_i;
            wbsel_p0   <= wbsel_i;
            funct3_p0  <= ld_funct3_i;
            pcsel_p0   <= pcsel_i;
            brtaken_p0 <= brtaken_i;
        end
    end

    // Non-loads commit straight from the inputs; loads commit from the holding register.
    assign use_hold    = (state_q == WAIT);
    assign src_pc      = use_hold ? pc_p0      : pc_i;
    assign src_alu     = use_hold ? alu_p0     : alu_res_i;
    assign src_rd      = use_hold ? rd_p0      : rd_i;
    assign src_rdwe    = use_hold ? rdwe_p0    : rdwe_i;
    assign src_wbsel   = use_hold ? wbsel_p0   : wbsel_i;
    assign src_funct3  = use_hold ? funct3_p0  : ld_funct3_i;
    assign src_pcsel   = use_hold ? pcsel_p0   : pcsel_i;
    assign src_brtaken = use_hold ? brtaken_p0 : brtaken_i;

    load_align #(
        .DWIDTH (DWIDTH)
    ) u_load_align (
        .rdata_i  (mem_rdata_i),
        .offset_i (src_alu[OW-1:0]),
        .funct3_i (src_funct3),
        .data_o   (ld_data)
    );

    assign pc4        = src_pc + AWIDTH'(WORD_STRIDE);
    assign redirect_d = src_pcsel || src_brtaken;
    assign rf_we_d    = src_rdwe && (src_rd != '0);
    assign next_pc_d  = redirect_d ? {src_alu[AWIDTH-1:1], 1'b0} : pc4;

    always_comb begin
        wdata_d = src_alu;
        case (wbsel_e'(src_wbsel))
            WB_MEM:  wdata_d = ld_data;
            WB_PC4:  wdata_d = DWIDTH'(pc4);
            default: wdata_d = src_alu;
        endcase
    end

    // ---- stage p1: registered commit outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_o   <= 1'b0;
            rf_we_o    <= 1'b0;
            redirect_o <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            next_pc_o  <= '0;
            retired_o  <= '0;
        end else begin
            commit_o   <= do_commit;
            rf_we_o    <= do_commit && rf_we_d;
            redirect_o <= do_commit && redirect_d;
            if (do_commit) begin
                rf_waddr_o <= src_rd;
                rf_wdata_o <= wdata_d;
                next_pc_o  <= next_pc_d;
                retired_o  <= retired_o + CWIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_writeback_pipe.sv
// Randomized bench for writeback_pipe with a transaction-level reference model.
module tb_writeback_pipe;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;
    localparam int CW = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [AW-1:0] pc_i;
    logic [DW-1:0] alu_res_i;
    logic [RW-1:0] rd_i;
    logic          rdwe_i;
    logic [1:0]    wbsel_i;
    logic          is_load_i;
    logic [2:0]    ld_funct3_i;
    logic          pcsel_i;
    logic          brtaken_i;
    logic          flush_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          rf_we_o;
    logic [RW-1:0] rf_waddr_o;
    logic [DW-1:0] rf_wdata_o;
    logic          redirect_o;
    logic          commit_o;
    logic [AW-1:0] next_pc_o;
    logic [CW-1:0] retired_o;

    writeback_pipe #(
        .DWIDTH (DW),
        .AWIDTH (AW),
        .RWIDTH (RW),
        .CWIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .pc_i         (pc_i),
        .alu_res_i    (alu_res_i),
        .rd_i         (rd_i),
        .rdwe_i       (rdwe_i),
        .wbsel_i      (wbsel_i),
        .is_load_i    (is_load_i),
        .ld_funct3_i  (ld_funct3_i),
        .pcsel_i      (pcsel_i),
        .brtaken_i    (brtaken_i),
        .flush_i      (flush_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .redirect_o   (redirect_o),
        .commit_o     (commit_o),
        .next_pc_o    (next_pc_o),
        .retired_o    (retired_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rdwe;
        logic [1:0]  wbsel;
        logic        is_load;
        logic [2:0]  f3;
        logic        pcsel;
        logic        brtaken;
    } instr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_retired;
    logic [31:0] last_wdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: pick the byte/half out of the word by arithmetic, then extend.
    function automatic logic [31:0] align_ref(input logic [31:0] rdata, input logic [31:0] addr,
                                              input logic [2:0] f3);
        int unsigned off;
        logic [31:0] b;
        logic [31:0] h;
        off = addr % 4;
        b   = (rdata >> (8 * off)) & 32'hFF;
        h   = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    function automatic instr_t mk(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] rd,
                                  input logic rdwe, input logic [1:0] wbsel, input logic ld,
                                  input logic [2:0] f3, input logic pcsel, input logic brtaken);
        instr_t i;
        i.pc = pc; i.alu = alu; i.rd = rd; i.rdwe = rdwe; i.wbsel = wbsel;
        i.is_load = ld; i.f3 = f3; i.pcsel = pcsel; i.brtaken = brtaken;
        return i;
    endfunction

    function automatic instr_t rand_instr(input logic ld);
        instr_t i;
        i.pc      = $urandom & 32'hFFFF_FFFC;
        i.alu     = $urandom;
        i.rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        i.rdwe    = 1'($urandom);
        i.is_load = ld;
        i.f3      = 3'($urandom);
        i.pcsel   = !ld && ($urandom_range(0, 3) == 0);
        i.brtaken = !ld && ($urandom_range(0, 3) == 0);
        if (ld) begin
            i.wbsel = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01;
        end else begin
            case ($urandom_range(0, 2))
                0:       i.wbsel = 2'b00;
                1:       i.wbsel = 2'b10;
                default: i.wbsel = 2'b11;
            endcase
        end
        return i;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid_i   = 1'b0;
        flush_i      = 1'b0;
        mem_rvalid_i = 1'b0;
        pc_i         = $urandom;
        alu_res_i    = $urandom;
        rd_i         = 5'($urandom);
        rdwe_i       = 1'($urandom);
        wbsel_i      = 2'($urandom);
        is_load_i    = 1'($urandom);
        ld_funct3_i  = 3'($urandom);
        pcsel_i      = 1'($urandom);
        brtaken_i    = 1'($urandom);
        mem_rdata_i  = $urandom;
    endtask

    task automatic drive_instr(input instr_t i);
        in_valid_i   = 1'b1;
        flush_i      = 1'b0;
        mem_rvalid_i = 1'b0;
        pc_i         = i.pc;
        alu_res_i    = i.alu;
        rd_i         = i.rd;
        rdwe_i       = i.rdwe;
        wbsel_i      = i.wbsel;
        is_load_i    = i.is_load;
        ld_funct3_i  = i.f3;
        pcsel_i      = i.pcsel;
        brtaken_i    = i.brtaken;
    endtask

    task automatic check_commit(input instr_t i, input logic [31:0] rdata);
        logic        redir;
        logic [31:0] pc4;
        logic [31:0] wd;
        redir = i.pcsel || i.brtaken;
        pc4   = i.pc + 32'd4;
        case (i.wbsel)
            2'b01:   wd = align_ref(rdata, i.alu, i.f3);
            2'b10:   wd = pc4;
            default: wd = i.alu;
        endcase
        exp_retired = exp_retired + 32'd1;
        chk("commit",   commit_o,   1'b1);
        chk("rf_we",    rf_we_o,    i.rdwe && (i.rd != 5'd0));
        chk("waddr",    rf_waddr_o, i.rd);
        chk("wdata",    rf_wdata_o, wd);
        chk("redirect", redirect_o, redir);
        chk("next_pc",  next_pc_o,  redir ? {i.alu[31:1], 1'b0} : pc4);
        chk("retired",  retired_o,  exp_retired);
        last_wdata = wd;
    endtask

    task automatic do_alu(input instr_t i);
        chk("rdy_acc", in_ready_o, 1'b1);
        drive_instr(i);
        step();
        drive_idle();
        check_commit(i, 32'd0);
    endtask

    task automatic do_load(input instr_t i, input int d, input logic [31:0] rdata);
        chk("rdy_acc", in_ready_o, 1'b1);
        drive_instr(i);
        step();
        for (int k = 1; k <= d; k++) begin
            drive_idle();
            in_valid_i = 1'($urandom);
            chk("rdy_wait", in_ready_o, 1'b0);
            chk("commit_wait", commit_o, 1'b0);
            if (k == d) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = rdata;
                flush_i      = 1'($urandom);
            end
            step();
        end
        drive_idle();
        check_commit(i, rdata);
    endtask

    task automatic do_flush_load(input instr_t i, input int d1, input int d2);
        chk("rdy_acc", in_ready_o, 1'b1);
        drive_instr(i);
        step();
        drive_idle();
        for (int k = 0; k < d1; k++) begin
            chk("rdy_wait", in_ready_o, 1'b0);
            step();
        end
        flush_i = 1'b1;
        chk("rdy_flush", in_ready_o, 1'b0);
        step();
        for (int k = 1; k <= d2; k++) begin
            drive_idle();
            in_valid_i = 1'($urandom);
            chk("rdy_drain", in_ready_o, 1'b0);
            chk("commit_drain", commit_o, 1'b0);
            if (k == d2) mem_rvalid_i = 1'b1;
            step();
        end
        drive_idle();
        chk("rdy_after_drain", in_ready_o, 1'b1);
        chk("commit_after_drain", commit_o, 1'b0);
        chk("we_after_drain", rf_we_o, 1'b0);
        chk("retired_flush", retired_o, exp_retired);
        chk("wdata_hold", rf_wdata_o, last_wdata);
    endtask

    task automatic do_blocked(input instr_t i);
        drive_instr(i);
        flush_i = 1'b1;
        step();
        drive_idle();
        chk("blocked_commit", commit_o, 1'b0);
        chk("blocked_rdy", in_ready_o, 1'b1);
        chk("blocked_retired", retired_o, exp_retired);
    endtask

    task automatic idle_gap(input int n);
        for (int k = 0; k < n; k++) begin
            drive_idle();
            mem_rvalid_i = 1'($urandom);
            step();
            chk("idle_commit", commit_o, 1'b0);
            chk("idle_we", rf_we_o, 1'b0);
            chk("idle_redirect", redirect_o, 1'b0);
            chk("idle_wdata_hold", rf_wdata_o, last_wdata);
        end
        drive_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy"},      in_ready_o, 1'b1);
        chk({tag, "_we"},       rf_we_o,    1'b0);
        chk({tag, "_waddr"},    rf_waddr_o, 5'd0);
        chk({tag, "_wdata"},    rf_wdata_o, 32'd0);
        chk({tag, "_redirect"}, redirect_o, 1'b0);
        chk({tag, "_commit"},   commit_o,   1'b0);
        chk({tag, "_next_pc"},  next_pc_o,  32'd0);
        chk({tag, "_retired"},  retired_o,  32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        instr_t ti;
        rst_n       = 1'b0;
        exp_retired = 32'd0;
        last_wdata  = 32'd0;
        drive_idle();
        step();
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        do_alu(mk(32'h100, 32'h1234, 5'd5, 1'b1, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0));
        chk("t_alu_wdata",   rf_wdata_o, 32'h1234);
        chk("t_alu_next_pc", next_pc_o,  32'h104);
        chk("t_alu_retired", retired_o,  32'd1);

        do_load(mk(32'h200, 32'h2003, 5'd7, 1'b1, 2'b01, 1'b1, 3'd0, 1'b0, 1'b0), 3, 32'h80AABBCC);
        chk("t_lb", rf_wdata_o, 32'hFFFFFF80);
        do_load(mk(32'h204, 32'h2003, 5'd7, 1'b1, 2'b01, 1'b1, 3'd4, 1'b0, 1'b0), 3, 32'h80AABBCC);
        chk("t_lbu", rf_wdata_o, 32'h00000080);
        do_load(mk(32'h208, 32'h2002, 5'd8, 1'b1, 2'b01, 1'b1, 3'd1, 1'b0, 1'b0), 1, 32'h80AABBCC);
        chk("t_lh_hi", rf_wdata_o, 32'hFFFF80AA);

        do_alu(mk(32'h40, 32'h2001, 5'd1, 1'b1, 2'b10, 1'b0, 3'd0, 1'b1, 1'b0));
        chk("t_jalr_redirect", redirect_o, 1'b1);
        chk("t_jalr_next_pc",  next_pc_o,  32'h2000);
        chk("t_jalr_wdata",    rf_wdata_o, 32'h44);

        do_alu(mk(32'h300, 32'h55, 5'd0, 1'b1, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0));
        chk("t_x0_we", rf_we_o, 1'b0);

        do_flush_load(mk(32'h400, 32'h10, 5'd3, 1'b1, 2'b01, 1'b1, 3'd2, 1'b0, 1'b0), 1, 2);
        do_blocked(mk(32'h500, 32'h77, 5'd4, 1'b1, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0));

        ti = mk(32'h600, 32'h2003, 5'd9, 1'b1, 2'b01, 1'b1, 3'd0, 1'b0, 1'b0);
        drive_instr(ti);
        step();
        drive_idle();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        exp_retired = 32'd0;
        last_wdata  = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEADBEEF;
        step();
        drive_idle();
        chk("rst_rvalid_commit", commit_o, 1'b0);
        chk("rst_rvalid_we", rf_we_o, 1'b0);
        do_alu(mk(32'h700, 32'h99, 5'd2, 1'b1, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0));
        chk("t_post_rst_retired", retired_o, 32'd1);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: do_alu(rand_instr(1'b0));
                4, 5, 6:    do_load(rand_instr(1'b1), $urandom_range(1, 4), $urandom);
                7:          do_flush_load(rand_instr(1'b1), $urandom_range(0, 3), $urandom_range(1, 3));
                8:          do_blocked(rand_instr(1'($urandom)));
                default:    idle_gap($urandom_range(1, 3));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
